// File: rtl/inst_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// FSM encodings, PC step and the {pc,inst} queue entry.
package inst_fetch_buffer_pkg;

   localparam logic [1:0] IFB_IDLE  = 2'd0;
   localparam logic [1:0] IFB_FETCH = 2'd1;
   localparam logic [1:0] IFB_DRAIN = 2'd2;

   localparam logic [31:0] IFB_PC_INC = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ifb_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Memory, core and redirect signals of the fetch buffer.
// master = fetch buffer side, slave = memory/core side.
interface inst_fetch_buffer_if;

   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output mem_req_valid, mem_req_addr,
      output inst_valid, inst, inst_pc,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  inst_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      input  inst_valid, inst, inst_pc,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output inst_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/ifb_fifo.sv
// DEPTH x {pc,inst} synchronous FIFO with flush and occupancy count.
// Head is read straight from the storage registers.
module ifb_fifo
   import inst_fetch_buffer_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  ifb_entry_t    i_data,
   output ifb_entry_t    o_head,
   output logic [CW-1:0] o_count
);

   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_count;
   ifb_entry_t    r_mem [DEPTH];
   logic          w_full;

   assign w_full  = (r_count == CW'(DEPTH));
   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
         unique case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr] <= i_data;
   end

   // full + pop + push is legal; full + push alone would overwrite the head
   always_ff @(posedge clk) begin
      if (rst_n && !i_flush) assert (!(i_push && w_full && !i_pop));
   end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Decoupled fetch front end: FSM, fetch PC, in-flight/discard counters, credits.
// Define IFB_BYPASS_EN for a zero-latency rsp->inst path when the FIFO is empty.
module inst_fetch_buffer
   import inst_fetch_buffer_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter int          MAX_OUTST = 2,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic                clk,
   input  logic                reset,
   inst_fetch_buffer_if.master bus
);

   localparam int            CW     = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   L_DEPTH = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] L_MAXO  = CW'(MAX_OUTST);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_rsp_pc;
   logic [31:0]   w_redir_pc;
   logic [CW-1:0] r_outst;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] w_discard_nxt;
   logic [CW-1:0] w_count;
   ifb_entry_t    w_head;
   ifb_entry_t    w_push_data;
   logic          w_redir;
   logic          w_rsp;
   logic          w_req;
   logic          w_fire;
   logic          w_drop;
   logic          w_push;
   logic          w_pop;
   logic          w_fifo_v;
   logic          w_byp;
   logic          w_byp_take;
   logic          w_unused;

   assign w_redir    = bus.redirect_valid;
   assign w_rsp      = bus.mem_rsp_valid;
   assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};
   assign w_unused   = ^bus.redirect_pc[1:0];
   assign w_fifo_v   = (w_count != '0);

   // credit rule: every in-flight word already owns a FIFO slot
   assign w_req = (r_state == IFB_FETCH) && !w_redir &&
                  (r_outst < L_MAXO) &&
                  (({1'b0, w_count} + {1'b0, r_outst}) < L_DEPTH);
   assign w_fire = w_req & bus.mem_req_ready;
   assign w_drop = w_rsp & (w_redir | (r_discard != '0));

`ifdef IFB_BYPASS_EN
   assign w_byp = w_rsp & !w_fifo_v & (r_discard == '0) & !w_redir;
   assign w_byp_take = w_byp & bus.inst_ready;
`else
   assign w_byp      = 1'b0;
   assign w_byp_take = 1'b0;
`endif

   assign w_push      = w_rsp & !w_drop & !w_byp_take;
   assign w_pop       = w_fifo_v & bus.inst_ready & !w_redir;
   assign w_push_data = '{pc: r_rsp_pc, inst: bus.mem_rsp_data};

   always_comb begin
      w_discard_nxt = r_discard;
      if (w_redir)
         w_discard_nxt = r_outst - CW'(w_rsp);
      else if (w_rsp && (r_discard != '0))
         w_discard_nxt = r_discard - 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IFB_IDLE:  w_state_nxt = IFB_FETCH;
         IFB_FETCH,
         IFB_DRAIN: w_state_nxt = (w_discard_nxt != '0) ? IFB_DRAIN : IFB_FETCH;
         default:   w_state_nxt = IFB_IDLE;
      endcase
   end

   // r_rsp_pc tracks the PC of the next response that will be kept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IFB_IDLE;
         r_fetch_pc <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_outst    <= '0;
         r_discard  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_discard <= w_discard_nxt;
         r_outst   <= r_outst + CW'(w_fire) - CW'(w_rsp);
         if (w_redir) begin
            r_fetch_pc <= w_redir_pc;
            r_rsp_pc   <= w_redir_pc;
         end else begin
            if (w_fire)           r_fetch_pc <= r_fetch_pc + IFB_PC_INC;
            if (w_rsp && !w_drop) r_rsp_pc   <= r_rsp_pc + IFB_PC_INC;
         end
      end
   end

   ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_redir),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign bus.mem_req_valid = w_req;
   assign bus.mem_req_addr  = r_fetch_pc;

   always_comb begin
      bus.inst_valid = 1'b0;
      bus.inst       = '0;
      bus.inst_pc    = '0;
      unique case (1'b1)
         w_fifo_v: begin
            bus.inst_valid = 1'b1;
            bus.inst       = w_head.inst;
            bus.inst_pc    = w_head.pc;
         end
         w_byp: begin
            bus.inst_valid = 1'b1;
            bus.inst       = bus.mem_rsp_data;
            bus.inst_pc    = r_rsp_pc;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer with an in-order variable-latency memory.
// Memory returns ~addr as the instruction word.
module tb_inst_fetch_buffer;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

`ifdef IFB_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic clk = 1'b0;
   logic reset;

   inst_fetch_buffer_if bus ();

   inst_fetch_buffer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          cyc    = 0;
   int          lat    = 1;
   int          n_acc  = 0;
   int          rel_cyc;
   int          base;
   int          amark;
   logic        found;
   pend_t       q[$];
   logic [31:0] acc_q[$];
   logic [31:0] cons_pc[$];
   int          cons_cyc[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] qget(input logic [31:0] qq[$],
                                        input int i);
      if (i < qq.size()) return qq[i];
      return 32'hDEAD_BEEF;
   endfunction

   // memory response side and cycle counter
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!reset) begin
         q.delete();
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = '0;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = ~q[0].addr;
         void'(q.pop_front());
      end else begin
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = '0;
      end
   end

   // request acceptance and core-side consumption
   always @(negedge clk) begin
      if (reset && bus.mem_req_valid && bus.mem_req_ready) begin
         q.push_back('{bus.mem_req_addr, cyc + lat});
         acc_q.push_back(bus.mem_req_addr);
         n_acc++;
      end
      if (reset && bus.inst_valid && bus.inst_ready &&
          !bus.redirect_valid) begin
         cons_pc.push_back(bus.inst_pc);
         cons_cyc.push_back(cyc);
         chk("inst_data", bus.inst, ~bus.inst_pc);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset              = 1'b0;
      bus.mem_req_ready  = 1'b1;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.mem_rsp_valid  = 1'b0;
      bus.mem_rsp_data   = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst", bus.inst, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);

      // streaming, latency 1
      tick();
      reset = 1'b1;
      bus.inst_ready = 1'b1;
      rel_cyc = cyc;
      n_acc = 0;
      @(negedge clk);
      chk("idle_req_valid", 32'(bus.mem_req_valid), 32'd0);
      @(negedge clk);
      chk("first_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("first_req_addr", bus.mem_req_addr, 32'h0);
      repeat (10) @(negedge clk);
      chk("first_latency", 32'(cons_cyc[0] - rel_cyc), 32'(3 - BYP));
      for (int i = 0; i < 8; i++)
         chk("stream_pc", qget(cons_pc, i), 32'(4 * i));
      for (int i = 1; i < 8; i++)
         chk("stream_gap", 32'(cons_cyc[i] - cons_cyc[i-1]), 32'd1);

      // core stall: buffer fills to DEPTH
      tick();
      bus.inst_ready = 1'b0;
      repeat (20) @(negedge clk);
      chk("stall_buffered", 32'(n_acc - cons_pc.size()), 32'd4);
      chk("stall_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("stall_inst_valid", 32'(bus.inst_valid), 32'd1);
      chk("stall_head_pc", bus.inst_pc, 32'(4 * cons_pc.size()));
      base = cons_pc.size();
      tick();
      bus.inst_ready = 1'b1;
      repeat (12) @(negedge clk);
      chk("resume_count", 32'(cons_pc.size() >= base + 8), 32'd1);
      for (int i = 0; i < cons_pc.size(); i++)
         chk("resume_seq", cons_pc[i], 32'(4 * i));

      // redirect with two requests in flight, latency 3
      tick();
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (q.size() == 2) found = 1'b1;
      end
      chk("two_outstanding", 32'(found), 32'd1);
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      base  = cons_pc.size();
      amark = acc_q.size();
      @(negedge clk);
      chk("redir_req_gated", 32'(bus.mem_req_valid), 32'd0);
      tick();
      bus.redirect_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("redir_fetch_addr", qget(acc_q, amark), 32'h100);
      chk("redir_pc0", qget(cons_pc, base), 32'h100);
      chk("redir_pc1", qget(cons_pc, base + 1), 32'h104);

      // redirect together with a response and a pop
      tick();
      lat = 1;
      bus.inst_ready = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      bus.inst_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h200;
      base = cons_pc.size();
      @(negedge clk);
      chk("coinc_rsp_valid", 32'(bus.mem_rsp_valid), 32'd1);
      chk("coinc_inst_valid", 32'(bus.inst_valid), 32'd1);
      tick();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("coinc_fifo_empty", 32'(bus.inst_valid), 32'd0);
      chk("coinc_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("coinc_req_addr", bus.mem_req_addr, 32'h200);
      repeat (6) @(negedge clk);
      chk("coinc_pc0", qget(cons_pc, base), 32'h200);
      chk("coinc_pc1", qget(cons_pc, base + 1), 32'h204);

      // empty-FIFO latency and unaligned redirect
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h103;
      tick();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("align_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("align_req_addr", bus.mem_req_addr, 32'h100);
      chk("align_inst_valid", 32'(bus.inst_valid), 32'd0);
      @(negedge clk);
      chk("lat_rsp_cycle", 32'(bus.inst_valid), 32'(BYP));
      @(negedge clk);
      chk("lat_next_valid", 32'(bus.inst_valid), 32'd1);
      chk("lat_next_pc", bus.inst_pc, (BYP != 0) ? 32'h104 : 32'h100);

      // reset mid-stream
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_req", 32'(bus.mem_req_valid), 32'd0);
      chk("mid_rst_ivalid", 32'(bus.inst_valid), 32'd0);
      chk("mid_rst_inst", bus.inst, 32'h0);
      chk("mid_rst_pc", bus.inst_pc, 32'h0);
      tick();
      tick();
      reset = 1'b1;
      cons_pc.delete();
      cons_cyc.delete();
      @(negedge clk);
      chk("mid_idle_req", 32'(bus.mem_req_valid), 32'd0);
      @(negedge clk);
      chk("mid_first_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("mid_first_addr", bus.mem_req_addr, 32'h0);
      repeat (5) @(negedge clk);
      chk("mid_pc0", qget(cons_pc, 0), 32'h0);
      chk("mid_pc1", qget(cons_pc, 1), 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
